// File: rtl/four12_window_max.sv
// four12_window_max: per-lane windowed peak detector for the FOUR12 SIMD adder.
// Tracks max/index/carry-OR of four 13-bit lanes over a programmable window.
//
// Ports:
//   clk_i, rst_n_i   clock, asynchronous active-low reset
//   clear_i          synchronous abort of the open window (wins over valid_i)
//   len_i            window length minus 1, sampled at window start
//   valid_i          P_i/CARRY_i carry a sample this cycle
//   P_i, CARRY_i     adder P (4 x 12-bit lanes) and per-lane CARRYOUT
//   max_o            lane k max at [13k+12:13k]
//   idx_o            lane k index of max at [LEN_BITS*k +: LEN_BITS]
//   ovf_o            per-lane OR of carries over the window
//   valid_o          one-cycle result pulse
module four12_window_max #(
    parameter int LEN_BITS  = 8,
    parameter bit USE_CARRY = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  clear_i,
    input  logic [LEN_BITS-1:0]   len_i,
    input  logic                  valid_i,
    input  logic [47:0]           P_i,
    input  logic [3:0]            CARRY_i,
    output logic [51:0]           max_o,
    output logic [4*LEN_BITS-1:0] idx_o,
    output logic [3:0]            ovf_o,
    output logic                  valid_o
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ACC  = 1'b1;

    logic [0:0]                 state;
    logic [LEN_BITS-1:0]        cnt;
    logic [LEN_BITS-1:0]        len_q;
    logic [3:0][12:0]           run_max;
    logic [3:0][LEN_BITS-1:0]   run_idx;
    logic [3:0]                 run_ovf;

    logic [3:0][12:0]           samp;
    logic [3:0][12:0]           nxt_max;
    logic [3:0][LEN_BITS-1:0]   nxt_idx;
    logic [3:0]                 nxt_ovf;
    logic                       start;
    logic                       fin;

    // Compare stage shared by window start and accumulation; the finishing
    // sample goes through the same compare before being published.
    always_comb begin
        samp    = '0;
        nxt_max = run_max;
        nxt_idx = run_idx;
        nxt_ovf = run_ovf;
        start   = (state == IDLE);
        fin     = start ? (len_i == '0) : (cnt == len_q);
        for (int k = 0; k < 4; k++) begin
            samp[k] = {USE_CARRY ? CARRY_i[k] : 1'b0, P_i[12*k +: 12]};
            if (start) begin
                nxt_max[k] = samp[k];
                nxt_idx[k] = '0;
                nxt_ovf[k] = CARRY_i[k];
            end else begin
                // Strict compare: ties keep the earliest index.
                if (samp[k] > run_max[k]) begin
                    nxt_max[k] = samp[k];
                    nxt_idx[k] = cnt;
                end
                nxt_ovf[k] = run_ovf[k] | CARRY_i[k];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= IDLE;
            cnt     <= '0;
            len_q   <= '0;
            run_max <= '0;
            run_idx <= '0;
            run_ovf <= '0;
            max_o   <= '0;
            idx_o   <= '0;
            ovf_o   <= '0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (clear_i) begin
                state   <= IDLE;
                cnt     <= '0;
                len_q   <= '0;
                run_max <= '0;
                run_idx <= '0;
                run_ovf <= '0;
            end else if (valid_i) begin
                if (start) begin
                    len_q <= len_i;
                end
                run_max <= nxt_max;
                run_idx <= nxt_idx;
                run_ovf <= nxt_ovf;
                if (fin) begin
                    state   <= IDLE;
                    cnt     <= '0;
                    max_o   <= nxt_max;
                    idx_o   <= nxt_idx;
                    ovf_o   <= nxt_ovf;
                    valid_o <= 1'b1;
                end else begin
                    state <= ACC;
                    cnt   <= start ? LEN_BITS'(1) : cnt + LEN_BITS'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_four12_window_max.sv
// tb_four12_window_max: table-driven, directed and random checks of
// four12_window_max (USE_CARRY=1 and USE_CARRY=0) against a queue model.
module tb_four12_window_max;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        valid;
    logic [7:0]  len;
    logic [47:0] p;
    logic [3:0]  c;

    logic [51:0] max_c1, max_c0;
    logic [31:0] idx_c1, idx_c0;
    logic [3:0]  ovf_c1, ovf_c0;
    logic        vo_c1, vo_c0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    four12_window_max #(.LEN_BITS(8), .USE_CARRY(1'b1)) u_c1 (
        .clk_i(clk), .rst_n_i(rst_n), .clear_i(clr), .len_i(len),
        .valid_i(valid), .P_i(p), .CARRY_i(c),
        .max_o(max_c1), .idx_o(idx_c1), .ovf_o(ovf_c1), .valid_o(vo_c1)
    );

    four12_window_max #(.LEN_BITS(8), .USE_CARRY(1'b0)) u_c0 (
        .clk_i(clk), .rst_n_i(rst_n), .clear_i(clr), .len_i(len),
        .valid_i(valid), .P_i(p), .CARRY_i(c),
        .max_o(max_c0), .idx_o(idx_c0), .ovf_o(ovf_c0), .valid_o(vo_c0)
    );

    // Reference model: keep the raw samples of the open window in queues and
    // evaluate the whole window when it is complete.
    bit          open;
    logic [7:0]  wlen;
    logic [47:0] qp[$];
    logic [3:0]  qc[$];
    logic        e_v;
    logic [51:0] e_max[2];
    logic [31:0] e_idx[2];
    logic [3:0]  e_ovf[2];

    function automatic void model_reset();
        open = 0;
        qp.delete();
        qc.delete();
        e_v = 1'b0;
        for (int u = 0; u < 2; u++) begin
            e_max[u] = '0;
            e_idx[u] = '0;
            e_ovf[u] = '0;
        end
    endfunction

    function automatic void model_finish();
        logic [12:0] mx, v;
        int          ix;
        logic        ov;
        for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < 4; k++) begin
                mx = '0;
                ix = 0;
                ov = 1'b0;
                for (int i = 0; i < qp.size(); i++) begin
                    v = {(u == 1) ? qc[i][k] : 1'b0, qp[i][12*k +: 12]};
                    if (i == 0 || v > mx) begin
                        mx = v;
                        ix = i;
                    end
                    ov = ov | qc[i][k];
                end
                e_max[u][13*k +: 13] = mx;
                e_idx[u][8*k +: 8]   = 8'(ix);
                e_ovf[u][k]          = ov;
            end
        end
    endfunction

    function automatic void model_step();
        e_v = 1'b0;
        if (clr) begin
            open = 0;
            qp.delete();
            qc.delete();
        end else if (valid) begin
            if (!open) begin
                open = 1;
                wlen = len;
                qp.delete();
                qc.delete();
            end
            qp.push_back(p);
            qc.push_back(c);
            if (qp.size() == int'(wlen) + 1) begin
                model_finish();
                e_v  = 1'b1;
                open = 0;
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("valid_c1", 64'(vo_c1), 64'(e_v));
        chk("valid_c0", 64'(vo_c0), 64'(e_v));
        chk("max_c1", 64'(max_c1), 64'(e_max[1]));
        chk("max_c0", 64'(max_c0), 64'(e_max[0]));
        chk("idx_c1", 64'(idx_c1), 64'(e_idx[1]));
        chk("idx_c0", 64'(idx_c0), 64'(e_idx[0]));
        chk("ovf_c1", 64'(ovf_c1), 64'(e_ovf[1]));
        chk("ovf_c0", 64'(ovf_c0), 64'(e_ovf[0]));
    endtask

    // Inputs are held from just after one edge to just after the next.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic cl, input logic [7:0] l,
                         input logic [47:0] pp, input logic [3:0] cc);
        valid = v;
        clr   = cl;
        len   = l;
        p     = pp;
        c     = cc;
        step();
    endtask

    typedef struct {
        logic        v;
        logic [7:0]  len;
        logic [11:0] l0;
        logic        ev;
        logic [12:0] emax0;
        logic [7:0]  eidx0;
        logic        eovf0;
    } vec_t;

    vec_t        tbl[5];
    logic [51:0] saved_max;
    logic [31:0] saved_idx;
    logic [47:0] pv;

    initial begin
        tbl[0] = '{1'b1, 8'd3, 12'h005, 1'b0, 13'h0, 8'd0, 1'b0};
        tbl[1] = '{1'b1, 8'd3, 12'h7FF, 1'b0, 13'h0, 8'd0, 1'b0};
        tbl[2] = '{1'b1, 8'd3, 12'h100, 1'b0, 13'h0, 8'd0, 1'b0};
        tbl[3] = '{1'b1, 8'd3, 12'h7FF, 1'b1, 13'h07FF, 8'd1, 1'b0};
        tbl[4] = '{1'b0, 8'd3, 12'h000, 1'b0, 13'h0, 8'd0, 1'b0};

        rst_n = 1'b0;
        clr   = 1'b0;
        valid = 1'b0;
        len   = '0;
        p     = '0;
        c     = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_max", 64'(max_c1), 64'h0);
        chk("rst_idx", 64'(idx_c1), 64'h0);
        chk("rst_ovf", 64'(ovf_c1), 64'h0);
        chk("rst_valid", 64'(vo_c1), 64'h0);
        rst_n = 1'b1;

        // Window of four with a tie on lane0.
        for (int i = 0; i < 5; i++) begin
            drive(tbl[i].v, 1'b0, tbl[i].len,
                  {12'h0A0, 12'h0A0, 12'h0A0, tbl[i].l0}, 4'h0);
            chk("tbl_valid", 64'(vo_c1), 64'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk("tbl_max0", 64'(max_c1[12:0]), 64'(tbl[i].emax0));
                chk("tbl_idx0", 64'(idx_c1[7:0]), 64'(tbl[i].eidx0));
                chk("tbl_ovf0", 64'(ovf_c1[0]), 64'(tbl[i].eovf0));
            end
        end

        // Carry extension on lane2.
        drive(1'b1, 1'b0, 8'd1, {12'h000, 12'hFFF, 24'h0}, 4'b0000);
        drive(1'b1, 1'b0, 8'd1, {12'h000, 12'h001, 24'h0}, 4'b0100);
        chk("cy1_max2", 64'(max_c1[38:26]), 64'h1001);
        chk("cy1_idx2", 64'(idx_c1[23:16]), 64'd1);
        chk("cy1_ovf2", 64'(ovf_c1[2]), 64'd1);
        chk("cy0_max2", 64'(max_c0[38:26]), 64'h0FFF);
        chk("cy0_idx2", 64'(idx_c0[23:16]), 64'd0);
        chk("cy0_ovf2", 64'(ovf_c0[2]), 64'd1);

        // One-sample windows, continuous stream.
        for (int i = 0; i < 5; i++) begin
            pv = {12'(4*i+3), 12'(4*i+2), 12'(4*i+1), 12'(4*i)};
            drive(1'b1, 1'b0, 8'd0, pv, 4'h0);
            chk("len0_valid", 64'(vo_c1), 64'd1);
            chk("len0_max", 64'(max_c1),
                64'({1'b0, pv[47:36], 1'b0, pv[35:24],
                     1'b0, pv[23:12], 1'b0, pv[11:0]}));
            chk("len0_idx", 64'(idx_c1), 64'd0);
        end
        drive(1'b0, 1'b0, 8'd0, '0, 4'h0);

        // Clear together with the 5th sample of a len=7 window.
        for (int i = 0; i < 4; i++)
            drive(1'b1, 1'b0, 8'd7, {4{12'hFFF}}, 4'hF);
        saved_max = max_c1;
        saved_idx = idx_c1;
        drive(1'b1, 1'b1, 8'd7, {4{12'hFFF}}, 4'hF);
        chk("clr_no_valid", 64'(vo_c1), 64'd0);
        chk("clr_hold_max", 64'(max_c1), 64'(saved_max));
        chk("clr_hold_idx", 64'(idx_c1), 64'(saved_idx));
        clr = 1'b0;
        for (int i = 0; i < 8; i++)
            drive(1'b1, 1'b0, 8'd7,
                  {12'(i*3), 12'(100 - i), 12'(i), 12'(i % 3)}, 4'h0);
        chk("post_clr_valid", 64'(vo_c1), 64'd1);
        chk("post_clr_max3", 64'(max_c1[51:39]), 64'd21);
        chk("post_clr_ovf", 64'(ovf_c1), 64'd0);

        // len_i changes mid-window; the latched length still applies.
        drive(1'b1, 1'b0, 8'd3, {4{12'h010}}, 4'h0);
        drive(1'b1, 1'b0, 8'd3, {4{12'h020}}, 4'h0);
        drive(1'b1, 1'b0, 8'd0, {4{12'h030}}, 4'h0);
        chk("lenchg_open", 64'(vo_c1), 64'd0);
        drive(1'b1, 1'b0, 8'd0, {4{12'h005}}, 4'h0);
        chk("lenchg_close", 64'(vo_c1), 64'd1);
        chk("lenchg_idx", 64'(idx_c1), 64'h02020202);

        // Asynchronous reset in the middle of a window, between edges.
        drive(1'b1, 1'b0, 8'd5, {4{12'h777}}, 4'h3);
        drive(1'b1, 1'b0, 8'd5, {4{12'h778}}, 4'h3);
        valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_max", 64'(max_c1), 64'h0);
        chk("arst_idx", 64'(idx_c1), 64'h0);
        chk("arst_ovf", 64'(ovf_c1), 64'h0);
        chk("arst_valid", 64'(vo_c1), 64'h0);
        model_reset();
        #1;
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 8'd2, {12'h001, 12'h300, 12'h002, 12'h010}, 4'h0);
        drive(1'b1, 1'b0, 8'd2, {12'h002, 12'h100, 12'h002, 12'h020}, 4'h1);
        drive(1'b1, 1'b0, 8'd2, {12'h003, 12'h200, 12'h001, 12'h005}, 4'h0);
        chk("arst_win_valid", 64'(vo_c1), 64'd1);
        chk("arst_win_max", 64'(max_c1),
            64'({13'h003, 13'h300, 13'h002, 13'h1020}));
        chk("arst_win_idx", 64'(idx_c1), 64'h02000001);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            valid = ($urandom_range(0, 3) != 0);
            clr   = ($urandom_range(0, 24) == 0);
            len   = (i % 97 == 0) ? 8'd30 : 8'($urandom_range(0, 6));
            p[31:0]  = $urandom;
            p[47:32] = 16'($urandom);
            c     = 4'($urandom);
            if ($urandom_range(0, 3) == 0) c = 4'h0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/four12_window_max.md
# four12_window_max

Per-lane windowed peak detector that sits directly downstream of the FOUR12 SIMD adder DSP. It consumes that adder's 48-bit P output (four 12-bit lanes) and 4-bit CARRYOUT each valid cycle, extends each lane to 13 bits, and tracks the per-lane maximum and its in-window sample index over a runtime-programmable window. At each window end it emits one result pulse.

## Interface
Parameters:
- LEN_BITS, 8, width of the window-length input and of each per-lane index.
- USE_CARRY, 1. When 1, the lane value is {carry, lane}. When 0, carry is ignored and the lane value is {1'b0, lane}.

Ports:
- clk_i  in  1  single clock. Everything is on the rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- clear_i  in  1  synchronous abort of the current window.
- len_i  in  LEN_BITS  window length minus 1, so a window holds len_i+1 samples.
- valid_i  in  1  P_i/CARRY_i hold a sample this cycle.
- P_i  in  48  adder P; lane k is P_i[12k+11:12k].
- CARRY_i  in  4  adder CARRYOUT; bit k belongs to lane k.
- max_o  out  52  lane k maximum, at max_o[13k+12:13k].
- idx_o  out  4*LEN_BITS  lane k index of its maximum, at idx_o[LEN_BITS*k+LEN_BITS-1:LEN_BITS*k].
- ovf_o  out  4  bit k is the OR of lane k carries over the window. This is reported even when USE_CARRY=0.
- valid_o  out  1  one-cycle pulse: max_o/idx_o/ovf_o hold a new window result.

## Operation
- States:
  - IDLE: no window open.
  - ACC: a window is open.
- Reset (rst_n_i low, asynchronous): state=IDLE; the sample counter, running max, running idx, running ovf, len latch, max_o, idx_o, ovf_o and valid_o all go to 0.
- In IDLE, when valid_i=1:
  - latch len_i;
  - load every lane's running max with its sample value;
  - set running idx=0, running ovf=CARRY_i, counter=1.
  - If the latched length is 0 (one-sample window), finish immediately and stay in IDLE. Otherwise move to ACC.
- In ACC, when valid_i=1, for each lane independently:
  - if the sample value is strictly greater than the running max, update the max and set idx to the current counter;
  - OR CARRY_i into the running ovf;
  - increment the counter.
  - Ties keep the earliest index.
- Window finish (the sample with counter value equal to the latched length):
  - the finishing sample is included in the compare;
  - the final max/idx/ovf are transferred to the output registers and valid_o is pulsed;
  - state returns to IDLE and the counter goes to 0.
- valid_i=0 in any state: nothing changes apart from valid_o deasserting.
- A new window may begin on the cycle immediately after a finish. Back-to-back windows have no dead cycle.
- len_i is sampled only at window start. Changes mid-window are ignored.
- clear_i=1:
  - state goes to IDLE and the counter and running registers go to 0;
  - a sample presented in the same cycle is dropped; clear wins over valid_i;
  - outputs max_o/idx_o/ovf_o keep their last result;
  - if the clear coincides with what would have been a finishing sample, no valid_o is produced.
- Comparison is unsigned 13-bit. Outputs are held between pulses.

## Timing
- Latency: a finishing sample accepted at edge t gives valid_o=1 and the new max_o/idx_o/ovf_o during cycle t+1 (registered, one cycle).
- valid_o is high for exactly one cycle per completed window. Two windows cannot finish in adjacent cycles unless len=0. With len=0, a stream of valid_i gives valid_o high every cycle.
- Every output is directly from a flop. No combinational path runs from the inputs to the outputs.
- Throughput: one sample per clock. There is no backpressure, and a stream of continuous valid_i is always accepted.
- Counter width is LEN_BITS, so the maximum window is 2^LEN_BITS samples. The counter never wraps within a window.
- Reset released mid-stream: the first valid_i after release opens a new window.

## Test plan
- Reset, then len_i=3 and four samples with lane0 = 0x005, 0x7FF, 0x100, 0x7FF and no carries:
  - valid_o pulses one cycle after the 4th sample;
  - lane0 max=0x07FF, idx=1 (tie keeps earliest), ovf=0.
- USE_CARRY=1, len_i=1:
  - lane2 sample 1 = 0xFFF with carry 0, sample 2 = 0x001 with carry 1;
  - required: lane2 max=0x1001, idx=1, ovf[2]=1.
  - Repeat with USE_CARRY=0: lane2 max=0x0FFF, idx=0, ovf[2]=1.
- len_i=0 with continuous valid_i for 5 cycles, lane-ascending data:
  - valid_o high for 5 consecutive cycles;
  - each result equals the corresponding input, with idx=0.
- len_i=7 with clear_i asserted together with the 5th sample:
  - no valid_o is produced;
  - the previous outputs are unchanged;
  - the next 8 samples produce a correct result that does not include pre-clear data.
- len_i changed from 3 to 0 after the 2nd sample of a window: that window still closes after 4 samples.
- Asynchronous reset asserted mid-window (between clock edges):
  - all outputs read 0 immediately;
  - after release, a fresh len_i=2 window completes with correct results.
